// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, register ids and
// the bubble encoding used by the D and E pipeline registers.
package decode_stage_pkg;

    localparam int WORD_W_DEF = 64;
    localparam int REG_W_DEF  = 4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] RR8   = 4'h8;
    localparam logic [3:0] RR9   = 4'h9;
    localparam logic [3:0] RR10  = 4'hA;
    localparam logic [3:0] RR11  = 4'hB;
    localparam logic [3:0] RR12  = 4'hC;
    localparam logic [3:0] RR13  = 4'hD;
    localparam logic [3:0] RR14  = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] BUBBLE_ICODE = INOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

    // Instructions whose result only exists after the memory stage.
    function automatic logic isLoadIcode(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ);
    endfunction

    function automatic logic usesValP(input logic [3:0] icode);
        return (icode == ICALL) || (icode == IJXX);
    endfunction

endpackage

// File: rtl/decode_stage_fwd_sel.sv
// Per-operand forwarding mux: valP override, then E/M/W bypass sources in
// pipeline-age order, falling back to the register-file read value.
module decode_stage_fwd_sel
    import decode_stage_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic [REG_W-1:0]  srcId,
    input  logic              useValP,
    input  logic [WORD_W-1:0] valP,
    input  logic [REG_W-1:0]  e_dstE,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [REG_W-1:0]  m_dstM,
    input  logic [WORD_W-1:0] m_valM,
    input  logic [REG_W-1:0]  M_dstE,
    input  logic [WORD_W-1:0] M_valE,
    input  logic [REG_W-1:0]  W_dstM,
    input  logic [WORD_W-1:0] W_valM,
    input  logic [REG_W-1:0]  W_dstE,
    input  logic [WORD_W-1:0] W_valE,
    input  logic [WORD_W-1:0] rfVal,
    output logic [WORD_W-1:0] fwdVal
);

    localparam logic [REG_W-1:0] NONE_ID = {REG_W{1'b1}};

    // An all-ones id means "no register" and must never look like a hit.
    function automatic logic idHit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return (src != NONE_ID) && (src == dst);
    endfunction

    // Youngest producer wins so the operand sees the most recent value.
    always_comb begin
        fwdVal = rfVal;
        if (useValP) begin
            fwdVal = valP;
        end else if (idHit(srcId, e_dstE)) begin
            fwdVal = e_valE;
        end else if (idHit(srcId, m_dstM)) begin
            fwdVal = m_valM;
        end else if (idHit(srcId, M_dstE)) begin
            fwdVal = M_valE;
        end else if (idHit(srcId, W_dstM)) begin
            fwdVal = W_valM;
        end else if (idHit(srcId, W_dstE)) begin
            fwdVal = W_valE;
        end else begin
            fwdVal = rfVal;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 PIPE decode stage: D pipeline register, register-id decode,
// operand forwarding, load-use interlock and the E pipeline register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_valid,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [REG_W-1:0]  f_rA,
    input  logic [REG_W-1:0]  f_rB,
    input  logic [WORD_W-1:0] f_valC,
    input  logic [WORD_W-1:0] f_valP,
    input  logic              ctl_bubble_d,
    input  logic              ctl_bubble_e,
    output logic [REG_W-1:0]  srcA,
    output logic [REG_W-1:0]  srcB,
    input  logic [WORD_W-1:0] rf_valA,
    input  logic [WORD_W-1:0] rf_valB,
    input  logic [REG_W-1:0]  e_dstE,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [REG_W-1:0]  m_dstM,
    input  logic [WORD_W-1:0] m_valM,
    input  logic [REG_W-1:0]  M_dstE,
    input  logic [WORD_W-1:0] M_valE,
    input  logic [REG_W-1:0]  W_dstM,
    input  logic [WORD_W-1:0] W_valM,
    input  logic [REG_W-1:0]  W_dstE,
    input  logic [WORD_W-1:0] W_valE,
    input  logic [REG_W-1:0]  E_dstM_q,
    input  logic [3:0]        E_icode_q,
    output logic              d_stall,
    output logic              E_valid,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [WORD_W-1:0] E_valC,
    output logic [WORD_W-1:0] E_valA,
    output logic [WORD_W-1:0] E_valB,
    output logic [REG_W-1:0]  E_dstE,
    output logic [REG_W-1:0]  E_dstM,
    output logic [REG_W-1:0]  E_srcA,
    output logic [REG_W-1:0]  E_srcB
);

    localparam logic [REG_W-1:0] NONE_ID = {REG_W{1'b1}};
    localparam logic [REG_W-1:0] RSP_ID  = REG_W'(RRSP);

    logic              dValid_r;
    logic [3:0]        dIcode_r;
    logic [3:0]        dIfun_r;
    logic [REG_W-1:0]  dRA_r;
    logic [REG_W-1:0]  dRB_r;
    logic [WORD_W-1:0] dValC_r;
    logic [WORD_W-1:0] dValP_r;

    logic [REG_W-1:0]  srcA_s;
    logic [REG_W-1:0]  srcB_s;
    logic [REG_W-1:0]  dstE_s;
    logic [REG_W-1:0]  dstM_s;
    logic [WORD_W-1:0] valA_s;
    logic [WORD_W-1:0] valB_s;
    logic              useValP_s;
    logic              loadUse_s;
    logic              stall_s;

    // Register-id decode; an invalid D slot reads and writes nothing.
    always_comb begin
        srcA_s = NONE_ID;
        srcB_s = NONE_ID;
        dstE_s = NONE_ID;
        dstM_s = NONE_ID;
        if (dValid_r) begin
            case (dIcode_r)
                IRRMOVQ: begin
                    srcA_s = dRA_r;
                    dstE_s = dRB_r;
                end
                IIRMOVQ: begin
                    dstE_s = dRB_r;
                end
                IRMMOVQ: begin
                    srcA_s = dRA_r;
                    srcB_s = dRB_r;
                end
                IMRMOVQ: begin
                    srcB_s = dRB_r;
                    dstM_s = dRA_r;
                end
                IOPQ: begin
                    srcA_s = dRA_r;
                    srcB_s = dRB_r;
                    dstE_s = dRB_r;
                end
                ICALL: begin
                    srcB_s = RSP_ID;
                    dstE_s = RSP_ID;
                end
                IRET: begin
                    srcA_s = RSP_ID;
                    srcB_s = RSP_ID;
                    dstE_s = RSP_ID;
                end
                IPUSHQ: begin
                    srcA_s = dRA_r;
                    srcB_s = RSP_ID;
                    dstE_s = RSP_ID;
                end
                IPOPQ: begin
                    srcA_s = RSP_ID;
                    srcB_s = RSP_ID;
                    dstE_s = RSP_ID;
                    dstM_s = dRA_r;
                end
                default: begin
                    srcA_s = NONE_ID;
                    srcB_s = NONE_ID;
                    dstE_s = NONE_ID;
                    dstM_s = NONE_ID;
                end
            endcase
        end else begin
            srcA_s = NONE_ID;
            srcB_s = NONE_ID;
            dstE_s = NONE_ID;
            dstM_s = NONE_ID;
        end
    end

    assign srcA = srcA_s;
    assign srcB = srcB_s;

    // A load in E cannot forward until it reaches M, so hold D for one cycle.
    assign loadUse_s = isLoadIcode(E_icode_q) && (E_dstM_q != NONE_ID) &&
                       ((E_dstM_q == srcA_s) || (E_dstM_q == srcB_s));
    assign stall_s   = loadUse_s && !reset;
    assign d_stall   = stall_s;
    assign useValP_s = usesValP(dIcode_r);

    decode_stage_fwd_sel #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwdA (
        .srcId(srcA_s), .useValP(useValP_s), .valP(dValP_r),
        .e_dstE(e_dstE), .e_valE(e_valE), .m_dstM(m_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .rfVal(rf_valA), .fwdVal(valA_s)
    );

    decode_stage_fwd_sel #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwdB (
        .srcId(srcB_s), .useValP(1'b0), .valP({WORD_W{1'b0}}),
        .e_dstE(e_dstE), .e_valE(e_valE), .m_dstM(m_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .rfVal(rf_valB), .fwdVal(valB_s)
    );

    // D pipeline register: stall holds even when a bubble is also requested.
    always_ff @(posedge clock) begin
        if (reset) begin
            dValid_r <= 1'b0;
            dIcode_r <= BUBBLE_ICODE;
            dIfun_r  <= BUBBLE_IFUN;
            dRA_r    <= NONE_ID;
            dRB_r    <= NONE_ID;
            dValC_r  <= {WORD_W{1'b0}};
            dValP_r  <= {WORD_W{1'b0}};
        end else if (!stall_s) begin
            if (ctl_bubble_d) begin
                dValid_r <= 1'b0;
                dIcode_r <= BUBBLE_ICODE;
                dIfun_r  <= BUBBLE_IFUN;
                dRA_r    <= NONE_ID;
                dRB_r    <= NONE_ID;
                dValC_r  <= {WORD_W{1'b0}};
                dValP_r  <= {WORD_W{1'b0}};
            end else begin
                dValid_r <= f_valid;
                dIcode_r <= f_icode;
                dIfun_r  <= f_ifun;
                dRA_r    <= f_rA;
                dRB_r    <= f_rB;
                dValC_r  <= f_valC;
                dValP_r  <= f_valP;
            end
        end
    end

    // E pipeline register: a load-use interlock inserts exactly one bubble.
    always_ff @(posedge clock) begin
        if (reset || ctl_bubble_e || loadUse_s) begin
            E_valid <= 1'b0;
            E_icode <= BUBBLE_ICODE;
            E_ifun  <= BUBBLE_IFUN;
            E_valC  <= {WORD_W{1'b0}};
            E_valA  <= {WORD_W{1'b0}};
            E_valB  <= {WORD_W{1'b0}};
            E_dstE  <= NONE_ID;
            E_dstM  <= NONE_ID;
            E_srcA  <= NONE_ID;
            E_srcB  <= NONE_ID;
        end else begin
            E_valid <= dValid_r;
            E_icode <= dIcode_r;
            E_ifun  <= dIfun_r;
            E_valC  <= dValC_r;
            E_valA  <= valA_s;
            E_valB  <= valB_s;
            E_dstE  <= dstE_s;
            E_dstM  <= dstM_s;
            E_srcA  <= srcA_s;
            E_srcB  <= srcB_s;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a spec-level model predicts the E
// register and the combinational read ids/stall; monitors compare them.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset, f_valid, ctl_bubble_d, ctl_bubble_e, d_stall;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB, srcA, srcB;
    logic [63:0] f_valC, f_valP, rf_valA, rf_valB;
    logic [3:0]  e_dstE, m_dstM, M_dstE, W_dstM, W_dstE, E_dstM_q, E_icode_q;
    logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic        E_valid;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .ctl_bubble_d(ctl_bubble_d), .ctl_bubble_e(ctl_bubble_e),
        .srcA(srcA), .srcB(srcB), .rf_valA(rf_valA), .rf_valB(rf_valB),
        .e_dstE(e_dstE), .e_valE(e_valE), .m_dstM(m_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .E_dstM_q(E_dstM_q), .E_icode_q(E_icode_q),
        .d_stall(d_stall), .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    typedef struct packed {
        logic        reset, fValid;
        logic [3:0]  fIcode, fIfun, fRA, fRB;
        logic [63:0] fValC, fValP;
        logic        bubD, bubE;
        logic [63:0] rfA, rfB;
        logic [3:0]  exDstE;  logic [63:0] exValE;
        logic [3:0]  memDstM; logic [63:0] memValM;
        logic [3:0]  mrDstE;  logic [63:0] mrValE;
        logic [3:0]  wbDstM;  logic [63:0] wbValM;
        logic [3:0]  wbDstE;  logic [63:0] wbValE;
        logic [3:0]  eDstMq, eIcodeq;
    } stim_t;

    typedef struct packed {
        logic valid; logic [3:0] icode, ifun, rA, rB; logic [63:0] valC, valP;
    } dmod_t;

    typedef struct packed {
        logic valid; logic [3:0] icode, ifun; logic [63:0] valC, valA, valB;
        logic [3:0] dstE, dstM, srcA, srcB;
    } eexp_t;

    typedef struct packed { logic [3:0] srcA, srcB; logic stall; } cexp_t;

    eexp_t eq[$];
    cexp_t cq[$];
    int    checks = 0;
    int    failures = 0;
    dmod_t md;
    bit    mdKnown = 1'b0;
    stim_t s;

    // Register usage straight from the Y86-64 instruction table.
    function automatic logic [3:0] mSrcA(input dmod_t d);
        if (!d.valid) return 4'hF;
        if (d.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return d.rA;
        if (d.icode inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] mSrcB(input dmod_t d);
        if (!d.valid) return 4'hF;
        if (d.icode inside {4'h4, 4'h5, 4'h6}) return d.rB;
        if (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] mDstE(input dmod_t d);
        if (!d.valid) return 4'hF;
        if (d.icode inside {4'h2, 4'h3, 4'h6}) return d.rB;
        if (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] mDstM(input dmod_t d);
        if (!d.valid) return 4'hF;
        if (d.icode inside {4'h5, 4'hB}) return d.rA;
        return 4'hF;
    endfunction
    function automatic bit mHazard(input dmod_t d, input stim_t st);
        return (st.eIcodeq inside {4'h5, 4'hB}) && (st.eDstMq != 4'hF) &&
               ((st.eDstMq == mSrcA(d)) || (st.eDstMq == mSrcB(d)));
    endfunction
    function automatic logic [63:0] mFwd(input logic [3:0] id, input bit useP,
                                         input logic [63:0] valP, input stim_t st,
                                         input logic [63:0] rf);
        logic [3:0]  ids [5];
        logic [63:0] vals [5];
        if (useP) return valP;
        ids[0] = st.exDstE;  vals[0] = st.exValE;
        ids[1] = st.memDstM; vals[1] = st.memValM;
        ids[2] = st.mrDstE;  vals[2] = st.mrValE;
        ids[3] = st.wbDstM;  vals[3] = st.wbValM;
        ids[4] = st.wbDstE;  vals[4] = st.wbValE;
        for (int i = 0; i < 5; i++) begin
            if (id != 4'hF && ids[i] == id) return vals[i];
        end
        return rf;
    endfunction

    task automatic quiet();
        s = '0;
        s.fIcode = 4'h1; s.fRA = 4'hF; s.fRB = 4'hF;
        s.rfA = {$urandom, $urandom}; s.rfB = {$urandom, $urandom};
        s.exDstE = 4'hF; s.memDstM = 4'hF; s.mrDstE = 4'hF; s.wbDstM = 4'hF; s.wbDstE = 4'hF;
        s.eDstMq = 4'hF; s.eIcodeq = 4'h1;
    endtask

    task automatic apply();
        cexp_t c;
        eexp_t e;
        bit    stall;
        reset = s.reset; f_valid = s.fValid; f_icode = s.fIcode; f_ifun = s.fIfun;
        f_rA = s.fRA; f_rB = s.fRB; f_valC = s.fValC; f_valP = s.fValP;
        ctl_bubble_d = s.bubD; ctl_bubble_e = s.bubE; rf_valA = s.rfA; rf_valB = s.rfB;
        e_dstE = s.exDstE; e_valE = s.exValE; m_dstM = s.memDstM; m_valM = s.memValM;
        M_dstE = s.mrDstE; M_valE = s.mrValE; W_dstM = s.wbDstM; W_valM = s.wbValM;
        W_dstE = s.wbDstE; W_valE = s.wbValE; E_dstM_q = s.eDstMq; E_icode_q = s.eIcodeq;
        stall = mdKnown && !s.reset && mHazard(md, s);
        if (mdKnown) begin
            c.srcA = mSrcA(md); c.srcB = mSrcB(md); c.stall = stall;
            cq.push_back(c);
        end
        if (s.reset || s.bubE || stall) begin
            e = '0; e.icode = 4'h1;
            e.dstE = 4'hF; e.dstM = 4'hF; e.srcA = 4'hF; e.srcB = 4'hF;
        end else begin
            e.valid = md.valid; e.icode = md.icode; e.ifun = md.ifun; e.valC = md.valC;
            e.valA = mFwd(mSrcA(md), md.icode inside {4'h7, 4'h8}, md.valP, s, s.rfA);
            e.valB = mFwd(mSrcB(md), 1'b0, 64'h0, s, s.rfB);
            e.dstE = mDstE(md); e.dstM = mDstM(md); e.srcA = mSrcA(md); e.srcB = mSrcB(md);
        end
        if (mdKnown || s.reset) eq.push_back(e);
        if (s.reset || (!stall && s.bubD)) begin
            md = '0; md.icode = 4'h1; md.rA = 4'hF; md.rB = 4'hF;
            mdKnown = 1'b1;
        end else if (!stall) begin
            md.valid = s.fValid; md.icode = s.fIcode; md.ifun = s.fIfun;
            md.rA = s.fRA; md.rB = s.fRB; md.valC = s.fValC; md.valP = s.fValP;
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        apply();
    endtask

    task automatic fetch(input logic [3:0] icode, input logic [3:0] rA, input logic [3:0] rB,
                         input logic [63:0] valP);
        s.fValid = 1'b1; s.fIcode = icode; s.fIfun = 4'h0; s.fRA = rA; s.fRB = rB;
        s.fValC = {$urandom, $urandom}; s.fValP = valP;
    endtask

    function automatic logic [3:0] rid();
        if ($urandom_range(0, 9) < 2) return 4'hF;
        return 4'($urandom_range(0, 7));
    endfunction

    // E-register monitor: compare once the registers have settled after the edge.
    initial begin
        eexp_t ex, ac;
        forever begin
            @(posedge clock);
            #1;
            if (eq.size() > 0) begin
                ex = eq.pop_front();
                ac.valid = E_valid; ac.icode = E_icode; ac.ifun = E_ifun; ac.valC = E_valC;
                ac.valA = E_valA; ac.valB = E_valB; ac.dstE = E_dstE; ac.dstM = E_dstM;
                ac.srcA = E_srcA; ac.srcB = E_srcB;
                checks++;
                if (ac !== ex) begin
                    failures++;
                    $display("FAIL ereg t=%0t got=%h want=%h", $time, ac, ex);
                end
            end
        end
    end

    // Combinational monitor: read ids and stall, just before the next edge.
    initial begin
        cexp_t ex, ac;
        forever begin
            @(negedge clock);
            #4;
            if (cq.size() > 0) begin
                ex = cq.pop_front();
                ac.srcA = srcA; ac.srcB = srcB; ac.stall = d_stall;
                checks++;
                if (ac !== ex) begin
                    failures++;
                    $display("FAIL comb t=%0t got srcA=%h srcB=%h stall=%b want srcA=%h srcB=%h stall=%b",
                             $time, ac.srcA, ac.srcB, ac.stall, ex.srcA, ex.srcB, ex.stall);
                end
            end
        end
    end

    initial begin
        quiet(); s.reset = 1'b1; cyc();
        quiet(); cyc();
        // OPQ rA=0 rB=3 with plain register-file operands.
        fetch(4'h6, 4'h0, 4'h3, 64'h10); cyc();
        quiet(); s.rfA = 64'd5; s.rfB = 64'd7; cyc();
        // Forward priority on srcA=2, then lower source, then srcA=RNONE.
        fetch(4'h6, 4'h2, 4'h5, 64'h20); cyc();
        fetch(4'h3, 4'hF, 4'h2, 64'h2A);
        s.exDstE = 4'h2; s.exValE = 64'd11; s.mrDstE = 4'h2; s.mrValE = 64'd22;
        s.wbDstE = 4'h2; s.wbValE = 64'd33; cyc();
        fetch(4'h6, 4'h2, 4'h5, 64'h34);
        s.mrDstE = 4'h2; s.mrValE = 64'd22; s.wbDstE = 4'h2; s.wbValE = 64'd33; cyc();
        quiet(); s.mrDstE = 4'h2; s.mrValE = 64'd22; s.wbDstE = 4'h2; s.wbValE = 64'd33; cyc();
        quiet(); s.rfA = 64'h1234; cyc();
        // Load-use: MRMOVQ to r1 in E while D holds OPQ rA=1.
        fetch(4'h6, 4'h1, 4'h3, 64'h50); cyc();
        s.eIcodeq = 4'h5; s.eDstMq = 4'h1; cyc();
        quiet(); s.memDstM = 4'h1; s.memValM = 64'd99; cyc();
        // CALL then PUSHQ.
        fetch(4'h8, 4'hF, 4'hF, 64'h40); cyc();
        fetch(4'hA, 4'h6, 4'hF, 64'h42); cyc();
        quiet(); cyc();
        // Hazard together with both control bubbles.
        fetch(4'h6, 4'h1, 4'h3, 64'h60); cyc();
        s.eIcodeq = 4'hB; s.eDstMq = 4'h1; s.bubD = 1'b1; s.bubE = 1'b1; cyc();
        quiet(); cyc();
        // Reset asserted in the middle of a stall.
        fetch(4'h6, 4'h1, 4'h3, 64'h70); cyc();
        s.eIcodeq = 4'h5; s.eDstMq = 4'h1; cyc();
        s.reset = 1'b1; cyc();
        s.reset = 1'b0; cyc();
        quiet(); cyc();

        for (int n = 0; n < 1500; n++) begin
            stim_t prev;
            prev = s;
            s.reset = ($urandom_range(0, 63) == 0);
            s.bubD = ($urandom_range(0, 9) == 0);
            s.bubE = ($urandom_range(0, 9) == 0);
            s.rfA = {$urandom, $urandom}; s.rfB = {$urandom, $urandom};
            s.exDstE = rid(); s.exValE = {$urandom, $urandom};
            s.memDstM = rid(); s.memValM = {$urandom, $urandom};
            s.mrDstE = rid(); s.mrValE = {$urandom, $urandom};
            s.wbDstM = rid(); s.wbValM = {$urandom, $urandom};
            s.wbDstE = rid(); s.wbValE = {$urandom, $urandom};
            s.eIcodeq = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB)
                                                    : 4'($urandom_range(0, 15));
            s.eDstMq = rid();
            if (!(mdKnown && !s.reset && mHazard(md, s))) begin
                s.fValid = ($urandom_range(0, 7) != 0);
                s.fIcode = ($urandom_range(0, 12) == 12) ? 4'($urandom_range(12, 15))
                                                         : 4'($urandom_range(0, 11));
                s.fIfun = 4'($urandom_range(0, 15));
                s.fRA = rid(); s.fRB = rid();
                s.fValC = {$urandom, $urandom}; s.fValP = {$urandom, $urandom};
            end else begin
                s.fValid = prev.fValid; s.fIcode = prev.fIcode; s.fIfun = prev.fIfun;
                s.fRA = prev.fRA; s.fRB = prev.fRB; s.fValC = prev.fValC; s.fValP = prev.fValP;
            end
            cyc();
        end

        @(posedge clock);
        #2;
        checks++;
        if (eq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL drain got eq=%0d cq=%0d want 0 0", eq.size(), cq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
